// File: rtl/video_line_fetch.sv
// Two-bank line prefetcher: bursts one 32-word line from memory per fetch_req, serves reads 1 cycle after vid_addr.
// mem_req is held until mem_ack; one pending request (overrun on replace). LINE_FETCH_TAG_CHECK_EN enables tag/valid hit checking.
module video_line_fetch #(
  parameter int          ADDR_W         = 16,
  parameter int unsigned FB_BASE        = 32'hD380,
  parameter int          WORDS_PER_LINE = 32,
  parameter int          LINES          = 342
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [8:0]        fetch_line,
  output logic              mem_req,
  output logic [ADDR_W:1]   mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  input  logic [14:1]       vid_addr,
  output logic [15:0]       vid_dout,
  output logic              busy,
  output logic              overrun
);

  localparam logic [4:0] LAST_WORD = 5'(WORDS_PER_LINE - 1);
  localparam logic [9:0] LINES_W   = 10'(LINES);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [4:0]        word;
  logic              bank;
  logic              pend_vld;
  logic [8:0]        pend_line;
  logic [15:0]       line_buf [64];

  logic              req_ok;
  logic              last_ack;
  logic              start;
  logic [8:0]        start_line;
  logic [ADDR_W-1:0] start_addr;

  assign req_ok   = fetch_req && ({1'b0, fetch_line} < LINES_W);
  assign last_ack = (state == FETCH) && mem_ack && (word == LAST_WORD);
  // A request arriving on the completion edge takes priority over the older pending one.
  assign start      = ((state == IDLE) && req_ok) || (last_ack && (req_ok || pend_vld));
  assign start_line = req_ok ? fetch_line : pend_line;
  assign start_addr = ADDR_W'(FB_BASE) + ADDR_W'({start_line, 5'b00000});

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_line <= '0;
      word      <= '0;
      bank      <= 1'b0;
    end else begin
      if ((state == FETCH) && req_ok && !last_ack) begin
        pend_vld  <= 1'b1;
        pend_line <= fetch_line;
      end
      if ((state == FETCH) && req_ok && pend_vld)
        overrun <= 1'b1;

      case (state)
        IDLE: ;
        FETCH: begin
          if (mem_ack) begin
            word     <= word + 5'd1;
            mem_addr <= mem_addr + ADDR_W'(1);
            if (word == LAST_WORD) begin
              state    <= IDLE;
              mem_req  <= 1'b0;
              busy     <= 1'b0;
              pend_vld <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state    <= FETCH;
        mem_req  <= 1'b1;
        busy     <= 1'b1;
        bank     <= start_line[0];
        word     <= '0;
        mem_addr <= start_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (state == FETCH) && mem_ack)
      line_buf[{bank, word}] <= mem_data;
  end

  logic hit;

`ifdef LINE_FETCH_TAG_CHECK_EN
  logic [1:0] valid;
  logic [8:0] tag [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 2'b00;
    end else begin
      if (last_ack)
        valid[bank] <= 1'b1;
      // Placed after the set so a same-parity restart leaves the bank invalid.
      if (start) begin
        valid[start_line[0]] <= 1'b0;
        tag[start_line[0]]   <= start_line;
      end
    end
  end

  assign hit = valid[vid_addr[6]] && (tag[vid_addr[6]] == vid_addr[14:6]);
`else
  logic unused_y;
  assign unused_y = ^vid_addr[14:7];
  assign hit      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      vid_dout <= 16'h0000;
    else
      vid_dout <= hit ? line_buf[{vid_addr[6], vid_addr[5:1]}] : 16'h0000;
  end

endmodule

// File: tb/tb_video_line_fetch.sv
// Self-checking bench for video_line_fetch: address scoreboard on the memory side, table-driven reads.
module tb_video_line_fetch;
  logic        clk;
  logic        reset, fetch_req, mem_req, mem_ack, busy, overrun;
  logic [8:0]  fetch_line;
  logic [16:1] mem_addr;
  logic [15:0] mem_data, vid_dout;
  logic [14:1] vid_addr;

  logic        fetch_req2, mem_req2, mem_ack2, busy2, overrun2;
  logic [8:0]  fetch_line2;
  logic [16:1] mem_addr2;
  logic [15:0] mem_data2, vid_dout2;
  logic [14:1] vid_addr2;

  video_line_fetch dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_line(fetch_line),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .vid_addr(vid_addr), .vid_dout(vid_dout), .busy(busy), .overrun(overrun)
  );

  video_line_fetch #(.FB_BASE(32'hFFF0)) dut2 (
    .clk(clk), .reset(reset), .fetch_req(fetch_req2), .fetch_line(fetch_line2),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_data(mem_data2),
    .vid_addr(vid_addr2), .vid_dout(vid_dout2), .busy(busy2), .overrun(overrun2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  line;
    logic [4:0]  word;
  } req_t;

  typedef struct {
    logic [8:0]  y;
    logic [4:0]  w;
    logic [15:0] exp;
  } rd_t;

  req_t        addr_q[$];
  rd_t         tab[12];
  logic [15:0] a2[64];
  int          n2 = 0;
  int          checks = 0, errors = 0;
  int          period = 1, ph = 0, ack_cnt = 0, hi = 0, gap = 0;

  function automatic logic [15:0] data_of(input logic [8:0] l, input logic [4:0] w);
    return {l[7:0], 3'b000, w};
  endfunction

  // Value read from a bank that holds line 'res' when another line of the same parity is asked for.
  function automatic logic [15:0] miss_val(input logic [8:0] res, input logic [4:0] w);
    logic [15:0] v;
    v = data_of(res, w);
`ifdef LINE_FETCH_TAG_CHECK_EN
    v = 16'h0000;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [8:0] l);
    req_t r;
    if (addr_q.size() == 0) ph = 0;
    ack_cnt = 0;
    for (int w = 0; w < 32; w++) begin
      r.addr = 16'hD380 + 16'({l, 5'd0}) + 16'(w);
      r.line = l;
      r.word = 5'(w);
      addr_q.push_back(r);
    end
  endtask

  task automatic request(input logic [8:0] l);
    fetch_req  = 1'b1;
    fetch_line = l;
    @(posedge clk); #1;
    fetch_req  = 1'b0;
  endtask

  task automatic rd(input logic [8:0] y, input logic [4:0] w, input logic [15:0] exp, input string name);
    vid_addr = {y, w};
    @(posedge clk); #1;
    chk(name, 32'(vid_dout), 32'(exp));
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (!mem_req && addr_q.size() == 0) done = 1'b1;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  // Memory model: acks every 'period' cycles, checks every presented address against the scoreboard.
  initial begin
    req_t r;
    mem_ack  = 1'b0;
    mem_data = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!reset && mem_req) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          ph++;
          if (ph >= period) begin
            ph = 0;
            r = addr_q.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(r.addr));
            mem_ack  = 1'b1;
            mem_data = data_of(r.line, r.word);
            ack_cnt++;
          end else begin
            chk("addr_stable", 32'(mem_addr), 32'(addr_q[0].addr));
          end
        end
      end
    end
  end

  initial begin
    mem_ack2  = 1'b0;
    mem_data2 = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack2 = mem_req2 && !reset;
      if (mem_ack2 && n2 < 64) begin
        a2[n2] = mem_addr2;
        n2++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (mem_req) hi++;
        else if (addr_q.size() != 0) gap++;
      end
    end
  end

  initial begin
    bit found;
    tab[0]  = '{9'd5, 5'd7,  data_of(9'd5, 5'd7)};
    tab[1]  = '{9'd5, 5'd0,  data_of(9'd5, 5'd0)};
    tab[2]  = '{9'd5, 5'd31, data_of(9'd5, 5'd31)};
    tab[3]  = '{9'd4, 5'd0,  data_of(9'd4, 5'd0)};
    tab[4]  = '{9'd4, 5'd31, data_of(9'd4, 5'd31)};
    tab[5]  = '{9'd4, 5'd17, data_of(9'd4, 5'd17)};
    tab[6]  = '{9'd6, 5'd3,  miss_val(9'd4, 5'd3)};
    tab[7]  = '{9'd7, 5'd2,  miss_val(9'd5, 5'd2)};
    tab[8]  = '{9'd0, 5'd9,  data_of(9'd0, 5'd9)};
    tab[9]  = '{9'd3, 5'd30, data_of(9'd3, 5'd30)};
    tab[10] = '{9'd5, 5'd1,  miss_val(9'd3, 5'd1)};
    tab[11] = '{9'd4, 5'd1,  miss_val(9'd0, 5'd1)};

    reset = 1'b1; fetch_req = 1'b0; fetch_line = '0; vid_addr = '0;
    fetch_req2 = 1'b0; fetch_line2 = '0; vid_addr2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req",  32'(mem_req),  32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_vid_dout", 32'(vid_dout), 32'd0);
    chk("reset_busy",     32'(busy),     32'd0);
    chk("reset_overrun",  32'(overrun),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait fill of line 5
    period = 1; hi = 0; gap = 0;
    request(9'd5);
    chk("latency_mem_req", 32'(mem_req), 32'd1);
    chk("latency_busy",    32'(busy),    32'd1);
    push_line(9'd5);
    wait_idle(100, "fill5");
    chk("fill5_req_cycles", 32'(hi),  32'd32);
    chk("fill5_gaps",       32'(gap), 32'd0);

    // Wait-state fill of line 4
    period = 3;
    request(9'd4);
    push_line(9'd4);
    wait_idle(300, "fill4");
    chk("fill4_acks",     32'(ack_cnt), 32'd32);
    chk("fill4_busy_low", 32'(busy),    32'd0);

    for (int i = 0; i < 8; i++)
      rd(tab[i].y, tab[i].w, tab[i].exp, $sformatf("table_read_%0d", i));

    // Pending replacement and overrun during line 0
    period = 1; hi = 0; gap = 0;
    request(9'd0);
    push_line(9'd0);
    request(9'd1);
    chk("overrun_one_pending", 32'(overrun), 32'd0);
    request(9'd2);
    request(9'd3);
    chk("overrun_set", 32'(overrun), 32'd1);
    push_line(9'd3);
    wait_idle(200, "pend");
    chk("pend_req_cycles", 32'(hi),      32'd64);
    chk("pend_gaps",       32'(gap),     32'd0);
    chk("overrun_sticky",  32'(overrun), 32'd1);

    for (int i = 8; i < 12; i++)
      rd(tab[i].y, tab[i].w, tab[i].exp, $sformatf("table_read_%0d", i));

    // Out-of-range lines are ignored
    request(9'd342);
    chk("oor_mem_req", 32'(mem_req), 32'd0);
    chk("oor_busy",    32'(busy),    32'd0);
    request(9'd511);
    repeat (3) @(posedge clk);
    #1;
    chk("oor_still_idle", 32'(mem_req), 32'd0);

    // Read at the final-ack edge: miss/old data, then hit
    request(9'd6);
    push_line(9'd6);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (addr_q.size() == 1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("last_word_reached", 32'(found), 32'd1);
    rd(9'd6, 5'd31, miss_val(9'd0, 5'd31), "read_at_final_ack");
    wait_idle(20, "fill6");
    rd(9'd6, 5'd31, data_of(9'd6, 5'd31), "read_after_fill6");

    // Reset at word 10 of line 8
    request(9'd8);
    push_line(9'd8);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (ack_cnt == 10) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("word10_reached", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_mem_req",  32'(mem_req),  32'd0);
    chk("midreset_busy",     32'(busy),     32'd0);
    chk("midreset_mem_addr", 32'(mem_addr), 32'd0);
    chk("midreset_overrun",  32'(overrun),  32'd0);
    chk("midreset_vid_dout", 32'(vid_dout), 32'd0);
    reset = 1'b0;
    addr_q.delete();
    @(posedge clk); #1;
    chk("after_reset_idle", 32'(mem_req), 32'd0);
    rd(9'd8, 5'd5,  miss_val(9'd8, 5'd5),  "aborted_read_w5");
    rd(9'd8, 5'd20, miss_val(9'd6, 5'd20), "aborted_read_w20");
    request(9'd8);
    push_line(9'd8);
    wait_idle(100, "refill8");
    chk("refill8_acks", 32'(ack_cnt), 32'd32);
    rd(9'd8, 5'd20, data_of(9'd8, 5'd20), "refill_read_w20");
    rd(9'd8, 5'd5,  data_of(9'd8, 5'd5),  "refill_read_w5");

    // Address wrap with FB_BASE 16'hFFF0
    fetch_req2 = 1'b1; fetch_line2 = 9'd0;
    @(posedge clk); #1;
    fetch_req2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (n2 >= 32 && !mem_req2) found = 1'b1;
    end
    chk("wrap_done",     32'(found),  32'd1);
    chk("wrap_count",    32'(n2),     32'd32);
    chk("wrap_word0",    32'(a2[0]),  32'hFFF0);
    chk("wrap_word15",   32'(a2[15]), 32'hFFFF);
    chk("wrap_word16",   32'(a2[16]), 32'h0000);
    chk("wrap_word31",   32'(a2[31]), 32'h000F);
    chk("wrap_busy_low", 32'(busy2),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
